// File: rtl/asp.sv
// Authenticated serial port: host words are parity-checked, tagged and held for
// the network until acknowledged; network words are tag-checked and delivered.
module asp #(
    parameter int                  data_size = 32,
    parameter int                  tag_size  = 8,
    parameter logic [tag_size-1:0] TAG_KEY   = 8'h8D
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_parity_ready_in,
    input  logic [data_size:0]            data_parity_in,
    input  logic                          network_data_ready_in,
    input  logic                          network_ACK_in,
    input  logic [data_size+tag_size-1:0] network_data_tag_in,
    output logic                          parity_error_out,
    output logic                          host_data_ready_out,
    output logic [data_size-1:0]          host_data_out,
    output logic                          network_data_ready_out,
    output logic                          network_ACK_out,
    output logic [data_size+tag_size-1:0] network_data_tag_out
);

    localparam int N_CHUNKS = (data_size + tag_size - 1) / tag_size;
    localparam int EXT_W    = N_CHUNKS * tag_size;

    typedef enum logic {IDLE, WAIT_ACK} tx_state_t;

    tx_state_t tx_state_reg;

    // Data is zero-extended to whole chunks so a partial top chunk folds cleanly.
    function automatic logic [tag_size-1:0] calc_tag(input logic [data_size-1:0] d);
        logic [EXT_W-1:0]    ext;
        logic [tag_size-1:0] acc;
        ext = EXT_W'(d);
        acc = TAG_KEY;
        for (int i = 0; i < N_CHUNKS; i++) begin
            acc = acc ^ ext[i*tag_size +: tag_size];
        end
        return acc;
    endfunction

    logic [data_size-1:0] tx_data;
    logic                 tx_parity_ok;
    logic [tag_size-1:0]  tx_tag;
    logic [data_size-1:0] rx_data;
    logic [tag_size-1:0]  rx_tag;
    logic                 rx_tag_ok;

    assign tx_data      = data_parity_in[data_size-1:0];
    assign tx_parity_ok = ~(^data_parity_in);
    assign tx_tag       = calc_tag(tx_data);

    assign rx_data   = network_data_tag_in[data_size+tag_size-1:tag_size];
    assign rx_tag    = network_data_tag_in[tag_size-1:0];
    assign rx_tag_ok = (rx_tag == calc_tag(rx_data));

    // TX path: one word in flight; new host words are dropped while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg           <= IDLE;
            parity_error_out       <= 1'b0;
            network_data_ready_out <= 1'b0;
            network_data_tag_out   <= '0;
        end else begin
            parity_error_out <= 1'b0;
            case (tx_state_reg)
                IDLE: begin
                    if (data_parity_ready_in) begin
                        if (tx_parity_ok) begin
                            network_data_tag_out   <= {tx_data, tx_tag};
                            network_data_ready_out <= 1'b1;
                            tx_state_reg           <= WAIT_ACK;
                        end else begin
                            parity_error_out <= 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (network_ACK_in) begin
                        network_data_ready_out <= 1'b0;
                        tx_state_reg           <= IDLE;
                    end
                end
                default: tx_state_reg <= IDLE;
            endcase
        end
    end

    // RX path: stateless, every valid-high edge is a fresh word.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_data_ready_out <= 1'b0;
            host_data_out       <= '0;
            network_ACK_out     <= 1'b0;
        end else begin
            host_data_ready_out <= 1'b0;
            network_ACK_out     <= 1'b0;
            if (network_data_ready_in && rx_tag_ok) begin
                host_data_out       <= rx_data;
                host_data_ready_out <= 1'b1;
                network_ACK_out     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_asp.sv
// Directed plus randomised bench for asp: a reference model pushes expected
// outputs per cycle into a queue, popped and compared one edge later.
module tb_asp;

    logic        clk;
    logic        reset;
    logic        data_parity_ready_in;
    logic [32:0] data_parity_in;
    logic        network_data_ready_in;
    logic        network_ACK_in;
    logic [39:0] network_data_tag_in;
    logic        parity_error_out;
    logic        host_data_ready_out;
    logic [31:0] host_data_out;
    logic        network_data_ready_out;
    logic        network_ACK_out;
    logic [39:0] network_data_tag_out;

    asp dut (
        .clk                    (clk),
        .reset                  (reset),
        .data_parity_ready_in   (data_parity_ready_in),
        .data_parity_in         (data_parity_in),
        .network_data_ready_in  (network_data_ready_in),
        .network_ACK_in         (network_ACK_in),
        .network_data_tag_in    (network_data_tag_in),
        .parity_error_out       (parity_error_out),
        .host_data_ready_out    (host_data_ready_out),
        .host_data_out          (host_data_out),
        .network_data_ready_out (network_data_ready_out),
        .network_ACK_out        (network_ACK_out),
        .network_data_tag_out   (network_data_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic        hr;
        logic [31:0] hd;
        logic        nr;
        logic        ack;
        logic [39:0] nt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    logic m_busy;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [7:0] ref_tag(input logic [31:0] d);
        return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ 8'h8D;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance the model with the currently driven inputs, queue its prediction,
    // clock once, then compare all outputs against the popped prediction.
    task automatic step(input string name);
        exp_t e;
        if (reset) begin
            m      = '{pe: 1'b0, hr: 1'b0, hd: 32'h0, nr: 1'b0, ack: 1'b0, nt: 40'h0};
            m_busy = 1'b0;
        end else begin
            m.pe = 1'b0;
            if (!m_busy) begin
                if (data_parity_ready_in) begin
                    if (^data_parity_in == 1'b0) begin
                        m.nt   = {data_parity_in[31:0], ref_tag(data_parity_in[31:0])};
                        m.nr   = 1'b1;
                        m_busy = 1'b1;
                    end else begin
                        m.pe = 1'b1;
                    end
                end
            end else if (network_ACK_in) begin
                m.nr   = 1'b0;
                m_busy = 1'b0;
            end
            m.hr  = 1'b0;
            m.ack = 1'b0;
            if (network_data_ready_in &&
                network_data_tag_in[7:0] == ref_tag(network_data_tag_in[39:8])) begin
                m.hd  = network_data_tag_in[39:8];
                m.hr  = 1'b1;
                m.ack = 1'b1;
            end
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("step %-10s pe=%b hr=%b hd=%h nr=%b ack=%b nt=%h", name,
                 parity_error_out, host_data_ready_out, host_data_out,
                 network_data_ready_out, network_ACK_out, network_data_tag_out);
        chk({name, ".pe"},  64'(parity_error_out),       64'(e.pe));
        chk({name, ".hr"},  64'(host_data_ready_out),    64'(e.hr));
        chk({name, ".hd"},  64'(host_data_out),          64'(e.hd));
        chk({name, ".nr"},  64'(network_data_ready_out), 64'(e.nr));
        chk({name, ".ack"}, 64'(network_ACK_out),        64'(e.ack));
        chk({name, ".nt"},  64'(network_data_tag_out),   64'(e.nt));
    endtask

    initial begin
        logic [31:0] d;
        m      = '{pe: 1'b0, hr: 1'b0, hd: 32'h0, nr: 1'b0, ack: 1'b0, nt: 40'h0};
        m_busy = 1'b0;
        reset                 = 1'b1;
        data_parity_ready_in  = 1'b0;
        data_parity_in        = '0;
        network_data_ready_in = 1'b0;
        network_ACK_in        = 1'b0;
        network_data_tag_in   = '0;
        #1;
        step("reset0");
        step("reset1");
        chk("reset_all", {network_data_tag_out, host_data_out[15:0], parity_error_out,
                          host_data_ready_out, network_data_ready_out, network_ACK_out,
                          4'h0} , 64'h0);
        reset = 1'b0;
        step("idle");

        // RX good tag, then bad tag with valid held high
        network_data_ready_in = 1'b1;
        network_data_tag_in   = 40'h00000012_34AB;
        step("rx_good");
        chk("rx_good_data", 64'(host_data_out), 64'h1234);
        chk("rx_good_ack",  64'(network_ACK_out), 64'h1);
        network_data_tag_in = 40'h00000012_34AC;
        step("rx_bad");
        chk("rx_bad_hold", 64'(host_data_out), 64'h1234);
        chk("rx_bad_rdy",  64'(host_data_ready_out), 64'h0);
        network_data_ready_in = 1'b0;
        step("rx_idle");

        // TX good parity, hold, busy drop, ACK
        data_parity_ready_in = 1'b1;
        data_parity_in       = 33'h1_00001234;
        step("tx_good");
        chk("tx_good_tag", 64'(network_data_tag_out), 64'h00000012_34AB);
        data_parity_ready_in = 1'b0;
        step("tx_hold1");
        step("tx_hold2");
        data_parity_ready_in = 1'b1;
        data_parity_in       = 33'h0;
        step("tx_busy");
        chk("tx_busy_keep", 64'(network_data_tag_out), 64'h00000012_34AB);
        data_parity_ready_in = 1'b0;
        network_ACK_in       = 1'b1;
        step("tx_ack");
        chk("tx_ack_drop", 64'(network_data_ready_out), 64'h0);
        step("ack_idle");
        network_ACK_in = 1'b0;

        // Parity error pulse
        data_parity_ready_in = 1'b1;
        data_parity_in       = 33'h0_00001234;
        step("tx_perr");
        chk("perr_pulse", 64'(parity_error_out), 64'h1);
        data_parity_ready_in = 1'b0;
        step("perr_end");
        chk("perr_clear", 64'(parity_error_out), 64'h0);

        // Zero data tag
        data_parity_ready_in = 1'b1;
        data_parity_in       = 33'h0;
        step("tx_zero");
        chk("zero_tag", 64'(network_data_tag_out), 64'h8D);
        data_parity_ready_in = 1'b0;
        step("zero_hold");

        // Reset mid-WAIT_ACK and mid-RX pulse
        network_data_ready_in = 1'b1;
        network_data_tag_in   = 40'h00000012_34AB;
        step("rx_pre_rst");
        network_data_ready_in = 1'b0;
        reset = 1'b1;
        step("mid_reset");
        chk("mid_reset_nr", 64'(network_data_ready_out), 64'h0);
        chk("mid_reset_hd", 64'(host_data_out), 64'h0);
        reset = 1'b0;
        step("post_reset");

        // Concurrent random TX/RX traffic
        for (int i = 0; i < 60; i++) begin
            d = $urandom;
            data_parity_ready_in = ($urandom_range(0, 2) != 0);
            data_parity_in       = {(^d) ^ ($urandom_range(0, 3) == 0), d};
            network_ACK_in       = ($urandom_range(0, 2) == 0);
            d = $urandom;
            network_data_ready_in = ($urandom_range(0, 1) != 0);
            network_data_tag_in   = {d, ref_tag(d) ^ 8'(($urandom_range(0, 3) == 0) ? 1 : 0)};
            step($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
